// File: rtl/aec_ref_align.sv
// Aligns the far-end reference to the microphone stream by a configurable bulk delay.
// Each accepted pair produces one aligned output pair: mic is passed through and spk is delayed.
module aec_ref_align #(
  parameter int DW    = 16,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_load,
  input  logic [AW-1:0] delay_cfg,
  input  logic          spk_valid,
  output logic          spk_ready,
  input  logic [DW-1:0] spk_data,
  input  logic          mic_valid,
  output logic          mic_ready,
  input  logic [DW-1:0] mic_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_mic,
  output logic [DW-1:0] out_spk,
  output logic          primed
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        state;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, fill, delay_q, rd_addr, fill_inc, fill_n, delay_n;
  logic          in_free, xfer;
  logic [DW-1:0] d, spk_sel;

  assign in_free   = !out_valid || out_ready;
  assign spk_ready = in_free && mic_valid;
  assign mic_ready = in_free && spk_valid;
  assign xfer      = spk_valid && mic_valid && in_free;

  // Read happens before the same-cycle write; delay 0 bypasses the memory entirely.
  assign rd_addr  = wp - delay_q;
  assign d        = (delay_q == '0) ? spk_data : mem[rd_addr];
  assign spk_sel  = (fill >= delay_q) ? d : '0;
  assign fill_inc = (fill == AW'(DEPTH-1)) ? fill : fill + 1'b1;

  // A coincident load wins over the transfer's fill increment.
  always_comb begin
    fill_n  = fill;
    delay_n = delay_q;
    if (xfer)     fill_n = fill_inc;
    if (cfg_load) begin
      fill_n  = '0;
      delay_n = delay_cfg;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) mem[wp] <= spk_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_mic   <= '0;
      out_spk   <= '0;
      wp        <= '0;
      fill      <= '0;
      delay_q   <= '0;
      primed    <= 1'b1;
    end else begin
      fill    <= fill_n;
      delay_q <= delay_n;
      primed  <= !cfg_load && (fill_n >= delay_n);
      if (xfer) begin
        out_mic <= mic_data;
        out_spk <= spk_sel;
        wp      <= wp + 1'b1;
      end
      case (state)
        IDLE: if (xfer) begin
          state     <= HOLD;
          out_valid <= 1'b1;
        end
        HOLD: if (!xfer && out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aec_ref_align.sv
// Scoreboard bench for aec_ref_align: expected pairs are queued at transfer time and
// compared whenever the output is valid, using an independent history-based delay model.
module tb_aec_ref_align;
  localparam int DW = 16, DEPTH = 64, AW = 6;

  logic          clk = 0, reset = 1, cfg_load = 0;
  logic [AW-1:0] delay_cfg = '0;
  logic          spk_valid = 0, mic_valid = 0, out_ready = 0;
  logic [DW-1:0] spk_data = '0, mic_data = '0;
  logic          spk_ready, mic_ready, out_valid, primed;
  logic [DW-1:0] out_mic, out_spk;

  int total = 0, bad = 0;

  aec_ref_align #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .delay_cfg(delay_cfg),
    .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_data(spk_data),
    .mic_valid(mic_valid), .mic_ready(mic_ready), .mic_data(mic_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_mic(out_mic),
    .out_spk(out_spk), .primed(primed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  logic [DW-1:0] q_mic[$], q_spk[$], hist[$];
  int            delay_m = 0, since_load = 0;
  logic          exp_valid = 0;

  always @(negedge clk) begin
    logic          free, xfer;
    logic [DW-1:0] e;
    if (reset) begin
      q_mic.delete(); q_spk.delete();
      exp_valid  = 0;
      delay_m    = 0;
      since_load = 0;
    end else begin
      chk("out_valid", out_valid, exp_valid);
      if (exp_valid && q_mic.size() > 0) begin
        chk("out_mic", out_mic, q_mic[0]);
        chk("out_spk", out_spk, q_spk[0]);
        if (out_ready) begin
          void'(q_mic.pop_front());
          void'(q_spk.pop_front());
        end
      end
      free = !exp_valid || out_ready;
      xfer = spk_valid && mic_valid && free;
      chk("spk_ready", spk_ready, free && mic_valid);
      chk("mic_ready", mic_ready, free && spk_valid);
      if (xfer) begin
        if (delay_m == 0)              e = spk_data;
        else if (since_load >= delay_m) e = hist[hist.size() - delay_m];
        else                           e = '0;
        q_mic.push_back(mic_data);
        q_spk.push_back(e);
        hist.push_back(spk_data);
        since_load++;
      end
      exp_valid = xfer ? 1'b1 : (exp_valid && !out_ready);
      if (cfg_load) begin
        delay_m    = int'(delay_cfg);
        since_load = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic sv, input logic mv, input logic [DW-1:0] s, input logic [DW-1:0] m);
    spk_valid = sv; mic_valid = mv; spk_data = s; mic_data = m;
  endtask

  initial begin
    step(); step();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_mic", out_mic, '0);
    chk("rst_spk", out_spk, '0);
    chk("rst_primed", primed, 1'b1);
    reset = 0;
    out_ready = 1;

    // delay 0 bypass, back-to-back
    drive(1, 1, 16'h2222, 16'h1111); step();
    drive(1, 1, 16'h4444, 16'h3333); step();
    drive(0, 0, 0, 0); step();
    chk("primed_d0", primed, 1'b1);
    step();

    // delay 3, primed rises with the third transfer
    cfg_load = 1; delay_cfg = 3; step();
    cfg_load = 0;
    chk("primed_load", primed, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, DW'(i + 1), DW'(16'hA0 + i)); step();
      chk("primed_d3", primed, (i >= 2));
    end
    drive(0, 0, 0, 0); step(); step();

    // backpressure: one pair accepted then held for 5 cycles
    out_ready = 0;
    drive(1, 1, 16'h0077, 16'h0C01); step();
    drive(1, 1, 16'h0078, 16'h0C02);
    for (int i = 0; i < 5; i++) begin
      chk("hold_ready", spk_ready, 1'b0);
      step();
    end
    out_ready = 1; step();
    drive(0, 0, 0, 0); step(); step();

    // join: spk alone must not transfer
    drive(1, 0, 16'h0099, 16'h0D01);
    for (int i = 0; i < 4; i++) begin
      chk("join_spk_ready", spk_ready, 1'b0);
      step();
    end
    mic_valid = 1; step();
    drive(0, 0, 0, 0); step(); step();

    // maximum delay across pointer wrap, with a few idle gaps
    cfg_load = 1; delay_cfg = 6'd63; step();
    cfg_load = 0;
    for (int i = 0; i < 130; i++) begin
      drive(1, 1, DW'(i), DW'(16'hB000 + i)); step();
      if (i % 37 == 36) begin drive(0, 0, 0, 0); step(); end
    end
    chk("primed_d63", primed, 1'b1);

    // load coincident with transfer: old delay used, fill restarts
    drive(1, 1, 16'h5000, 16'hE000);
    cfg_load = 1; delay_cfg = 2; step();
    cfg_load = 0;
    chk("primed_coinc", primed, 1'b0);
    for (int i = 1; i < 4; i++) begin
      drive(1, 1, DW'(16'h5000 + i), DW'(16'hE000 + i)); step();
    end
    out_ready = 0;
    drive(1, 1, 16'h5004, 16'hE004); step();
    drive(0, 0, 0, 0); step();
    chk("hold_before_rst", out_valid, 1'b1);
    reset = 1; #1;
    chk("rst_hold_valid", out_valid, 1'b0);
    chk("rst_hold_mic", out_mic, '0);
    chk("rst_hold_spk", out_spk, '0);
    step();
    reset = 0; out_ready = 1;
    drive(1, 1, 16'h6001, 16'hF001); step();
    chk("post_rst_valid", out_valid, 1'b1);
    chk("post_rst_spk", out_spk, 16'h6001);
    drive(0, 0, 0, 0); step(); step();
    chk("drain", q_mic.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end
endmodule
